alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 203 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add and divide is radix-2 restoring. Both work
// on operand magnitudes and take WIDTH cycles. Signs are applied in a
// single fix-up cycle before HI/LO are written.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  // Magnitude of a possibly-signed operand; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    logic [WIDTH-1:0] r;
    r = sgn ? -v : v;
    return r;
  endfunction

  // Conditional two's-complement negation of a single-width result.
  function automatic logic [WIDTH-1:0] sfix(input logic [WIDTH-1:0] m,
                                            input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(m);
    return neg ? -s : s;
  endfunction

  // Conditional two's-complement negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] sfix2(input logic [2*WIDTH-1:0] m,
                                               input logic neg);
    logic signed [2*WIDTH-1:0] s;
    s = $signed(m);
    return neg ? -s : s;
  endfunction

  logic [1:0]       state;
  logic [CW-1:0]    cnt;

  // Operands and flags captured at issue.
  logic             is_div_p0;
  logic             neg_q_p0;
  logic             neg_r_p0;
  logic             bz_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] opnd_p0;

  // Iteration registers. acc holds the product high half or the partial
  // remainder. q holds the multiplier or the dividend/quotient.
  logic [WIDTH:0]   acc_p1;
  logic [WIDTH-1:0] q_p1;

  logic             go_calc;
  logic             go_mt;
  logic             fix_commit;
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy       = (state != IDLE);
  assign go_calc    = (state == IDLE) && start && (op[2] == 1'b0);
  assign go_mt      = (state == IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
  assign fix_commit = (state == FIX) && !flush;

  // Only MULT (000) and DIV (010) treat operands as signed.
  assign sa_in = ~op[0] & A[WIDTH-1];
  assign sb_in = ~op[0] & B[WIDTH-1];

  // One shift-add / restoring-divide step, plus the sign fix-up values.
  always_comb begin
    mul_sum   = acc_p1 + (q_p1[0] ? {1'b0, opnd_p0} : '0);
    div_shift = {acc_p1[WIDTH-1:0], q_p1[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_p0};
    prod_fix  = sfix2({acc_p1[WIDTH-1:0], q_p1}, neg_q_p0);
    quo_fix   = sfix(q_p1, neg_q_p0);
    rem_fix   = sfix(acc_p1[WIDTH-1:0], neg_r_p0);
  end

  // Control FSM: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE; flush aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_calc) begin
            state <= CALC;
            cnt   <= CW'(WIDTH);
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Operand capture at issue, then one datapath step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_p0 <= 1'b0;
      neg_q_p0  <= 1'b0;
      neg_r_p0  <= 1'b0;
      bz_p0     <= 1'b0;
      a_p0      <= '0;
      opnd_p0   <= '0;
      acc_p1    <= '0;
      q_p1      <= '0;
    end else if (go_calc) begin
      is_div_p0 <= op[1];
      neg_q_p0  <= sa_in ^ sb_in;
      neg_r_p0  <= op[1] & sa_in;
      bz_p0     <= op[1] & (B == '0);
      a_p0      <= A;
      opnd_p0   <= op[1] ? mag(B, sb_in) : mag(A, sa_in);
      q_p1      <= op[1] ? mag(A, sa_in) : mag(B, sb_in);
      acc_p1    <= '0;
    end else if (state == CALC) begin
      if (is_div_p0) begin
        if (!div_trial[WIDTH]) begin
          acc_p1 <= div_trial;
          q_p1   <= {q_p1[WIDTH-2:0], 1'b1};
        end else begin
          acc_p1 <= div_shift;
          q_p1   <= {q_p1[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_p1 <= {1'b0, mul_sum[WIDTH:1]};
        q_p1   <= {mul_sum[0], q_p1[WIDTH-1:1]};
      end
    end
  end

  // HI/LO write-back at FIX or MTHI/MTLO, with the one-cycle done/dz pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (fix_commit) begin
        done <= 1'b1;
        if (is_div_p0 && bz_p0) begin
          hi <= a_p0;
          lo <= '1;
          dz <= 1'b1;
        end else if (is_div_p0) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end else if (go_mt) begin
        done <= 1'b1;
        if (op == OP_MTHI) hi <= A;
        else               lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int ndone;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps negedges until done, reporting the cycle number it appeared in.
  task automatic wait_done(input int from, output int l);
    l = from;
    while (done !== 1'b1 && l < 60) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi,
                     input logic [W-1:0] elo, input logic edz);
    int l;
    issue(o, a, b);
    wait_done(1, l);
    chk({tag, " latency"}, W'(l), 32'd34);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " dz"}, {31'd0, dz}, {31'd0, edz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; A = '0; B = '0;

    // Reset state
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst dz",   {31'd0, dz},   32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    // MULTU max*max, started on the first edge after reset release
    rst_n = 1'b1;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu busy c1", {31'd0, busy}, 32'd1);
    chk("multu hi hold c1", hi, 32'd0);
    repeat (19) @(negedge clk);
    chk("multu lo hold c20", lo, 32'd0);
    repeat (13) @(negedge clk);
    chk("multu busy c33", {31'd0, busy}, 32'd1);
    chk("multu done c33", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("multu done c34", {31'd0, done}, 32'd1);
    chk("multu busy c34", {31'd0, busy}, 32'd0);
    chk("multu hi", hi, 32'hFFFFFFFE);
    chk("multu lo", lo, 32'h00000001);
    chk("multu dz", {31'd0, dz}, 32'd0);

    // Back-to-back ops, each issued in the previous done cycle
    run("mult -3*7",   3'b000, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("div -7/2",    3'b010, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("divu 7/2",    3'b011, 32'd7,        32'd2,       32'd1,        32'd3,        1'b0);
    run("div min/-1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,       32'h80000000, 1'b0);
    run("divu 5/0",    3'b011, 32'd5,        32'd0,       32'd5,        32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("dz clears", {31'd0, dz}, 32'd0);
    chk("done pulse", {31'd0, done}, 32'd0);
    run("div 7/-2",    3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, 1'b0);
    run("mult min*min", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,     1'b0);
    run("div -5/0",    3'b010, 32'hFFFFFFFB, 32'd0,       32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run("mult -1*-1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,       32'd1,        1'b0);
    run("multu 3*5",   3'b001, 32'd3,        32'd5,       32'd0,        32'd15,       1'b0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    op = 3'b100; A = 32'hA5A5A5A5; start = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mthi done", {31'd0, done}, 32'd1);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi dz",   {31'd0, dz},   32'd0);
    chk("mthi hi", hi, 32'hA5A5A5A5);
    chk("mthi lo kept", lo, 32'd15);
    op = 3'b101; A = 32'h5A5A5A5A;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("mtlo done", {31'd0, done}, 32'd1);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    chk("mtlo lo", lo, 32'h5A5A5A5A);
    chk("mtlo hi kept", hi, 32'hA5A5A5A5);
    @(negedge clk);
    chk("mt done ends", {31'd0, done}, 32'd0);

    // Reserved opcode does nothing
    op = 3'b110; A = 32'h12345678; B = 32'h1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("rsvd done", {31'd0, done}, 32'd0);
    chk("rsvd busy", {31'd0, busy}, 32'd0);
    chk("rsvd hi", hi, 32'hA5A5A5A5);
    chk("rsvd lo", lo, 32'h5A5A5A5A);

    // Flush mid-operation, with an ignored start in between
    op = 3'b100; A = 32'h11111111; start = 1'b1;
    @(posedge clk); @(negedge clk);
    op = 3'b101;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    issue(3'b001, 32'hFFFFFFFF, 32'd3);
    repeat (4) @(negedge clk);
    op = 3'b011; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("flush busy c6", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy c11", {31'd0, busy}, 32'd0);
    chk("flush done c11", {31'd0, done}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("flush no done", W'(ndone), 32'd0);
    chk("flush hi", hi, 32'h11111111);
    chk("flush lo", lo, 32'h11111111);

    // Flush and start together in IDLE: start wins
    op = 3'b011; A = 32'd7; B = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; flush = 1'b0;
    wait_done(1, lat);
    chk("startwins latency", W'(lat), 32'd34);
    chk("startwins lo", lo, 32'd3);
    chk("startwins hi", hi, 32'd1);

    // Start while busy is ignored
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op = 3'b001; A = 32'd3; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    chk("ignore latency", W'(lat), 32'd34);
    chk("ignore lo", lo, 32'd14);
    chk("ignore hi", hi, 32'd2);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    issue(3'b010, 32'hFFFFFF9C, 32'd7);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst dz",   {31'd0, dz},   32'd0);
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    op = 3'b011; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
    chk("post-rst latency", W'(lat), 32'd34);
    chk("post-rst lo", lo, 32'd14);
    chk("post-rst hi", hi, 32'd2);
    chk("post-rst dz", {31'd0, dz}, 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
